led_pattern_sequencer: RTL and testbench

//  Hardware sequencer for the 18-bit red-LED PIO. Avalon-MM slave for CPU control (mode, period,

---
 rtl/led_pattern_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Animates the 18-bit red-LED PIO without CPU involvement. The CPU programs
//   mode, period and pattern through an Avalon-MM slave; the block pushes each
//   new pattern to the LED PIO data register through single-cycle master writes.
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   avs_address/chipselect/write_n   slave: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS
//   avs_writedata, avs_readdata      slave data (readdata combinational, zero-extended)
//   pio_chipselect/write_n/address   master strobes to the LED PIO (registered)
//   pio_writedata                    {zeros, pattern} (registered)
//   irq                              STATUS.step & CTRL.irq_en
module led_pattern_sequencer #(
  parameter int unsigned LED_WIDTH      = 18,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [1:0]  pio_address,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  MODE_ROTL   = 2'd0;
  localparam logic [1:0]  MODE_ROTR   = 2'd1;
  localparam logic [1:0]  MODE_BOUNCE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_enable;
  logic [1:0]           r_mode;
  logic                 r_irq_en;
  logic [CNT_WIDTH-1:0] r_period;
  logic [LED_WIDTH-1:0] r_pattern;
  logic                 r_step;
  logic                 r_dir_right;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pio_cs;
  logic                 r_pio_wn;
  logic [DATA_W-1:0]    r_pio_wd;
  logic                 r_irq;

  logic                 w_wr;
  logic                 w_wr_ctrl;
  logic                 w_wr_period;
  logic                 w_wr_pattern;
  logic                 w_wr_status;
  logic                 w_en_nxt;
  logic                 w_irq_en_nxt;
  logic                 w_step;
  logic                 w_step_nxt;
  logic [CNT_WIDTH-1:0] w_reload;
  logic [LED_WIDTH-1:0] w_next_pattern;
  logic                 w_next_dir;

  // Slave write decode; enable/irq_en look-ahead lets a CTRL write act on the same edge
  assign w_wr         = avs_chipselect & ~avs_write_n;
  assign w_wr_ctrl    = w_wr & (avs_address == 2'd0);
  assign w_wr_period  = w_wr & (avs_address == 2'd1);
  assign w_wr_pattern = w_wr & (avs_address == 2'd2);
  assign w_wr_status  = w_wr & (avs_address == 2'd3);
  assign w_en_nxt     = w_wr_ctrl ? avs_writedata[0] : r_enable;
  assign w_irq_en_nxt = w_wr_ctrl ? avs_writedata[3] : r_irq_en;

  // A step is the terminal count while still enabled; a coinciding CPU pattern write wins
  assign w_step     = (r_state == ST_COUNT) && (r_cnt == '0) && w_en_nxt && !w_wr_pattern;
  assign w_step_nxt = w_step | (r_step & ~(w_wr_status & avs_writedata[1]));

  // Reload of PERIOD-2: one cycle in UPDATE plus count-down to zero gives PERIOD spacing
  assign w_reload = (r_period <= CNT_WIDTH'(2)) ? '0 : r_period - CNT_WIDTH'(2);

  // Next pattern for the current mode; bounce also yields the new direction
  always_comb begin
    w_next_pattern = r_pattern;
    w_next_dir     = r_dir_right;
    case (r_mode)
      MODE_ROTL: w_next_pattern = {r_pattern[LED_WIDTH-2:0], r_pattern[LED_WIDTH-1]};
      MODE_ROTR: w_next_pattern = {r_pattern[0], r_pattern[LED_WIDTH-1:1]};
      MODE_BOUNCE: begin
        w_next_pattern = r_dir_right ? (r_pattern >> 1) : (r_pattern << 1);
        if (w_next_pattern[LED_WIDTH-1]) w_next_dir = 1'b1;
        else if (w_next_pattern[0])      w_next_dir = 1'b0;
      end
      default:   w_next_pattern = r_pattern + LED_WIDTH'(1);
    endcase
  end

  // Register readback
  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      2'd0:    avs_readdata = {28'd0, r_irq_en, r_mode, r_enable};
      2'd1:    avs_readdata = DATA_W'(r_period);
      2'd2:    avs_readdata = DATA_W'(r_pattern);
      default: avs_readdata = {30'd0, r_step, (r_state != ST_IDLE)};
    endcase
  end

  // Control registers, sequencer FSM and PIO master outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_enable    <= 1'b0;
      r_mode      <= 2'd0;
      r_irq_en    <= 1'b0;
      r_period    <= CNT_WIDTH'(DEFAULT_PERIOD);
      r_pattern   <= '0;
      r_step      <= 1'b0;
      r_dir_right <= 1'b0;
      r_cnt       <= '0;
      r_pio_cs    <= 1'b0;
      r_pio_wn    <= 1'b1;
      r_pio_wd    <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_pio_cs <= 1'b0;
      r_pio_wn <= 1'b1;
      r_step   <= w_step_nxt;
      r_irq    <= w_step_nxt & w_irq_en_nxt;

      if (w_wr_period) r_period <= avs_writedata[CNT_WIDTH-1:0];

      if (w_wr_pattern) begin
        r_pattern <= avs_writedata[LED_WIDTH-1:0];
        r_pio_cs  <= 1'b1;
        r_pio_wn  <= 1'b0;
        r_pio_wd  <= DATA_W'(avs_writedata[LED_WIDTH-1:0]);
      end else if (w_step) begin
        r_pattern <= w_next_pattern;
        r_pio_cs  <= 1'b1;
        r_pio_wn  <= 1'b0;
        r_pio_wd  <= DATA_W'(w_next_pattern);
        if (r_mode == MODE_BOUNCE) r_dir_right <= w_next_dir;
      end

      // Mode changes apply from the next step; entering bounce restarts leftwards
      if (w_wr_ctrl) begin
        r_enable <= avs_writedata[0];
        r_mode   <= avs_writedata[2:1];
        r_irq_en <= avs_writedata[3];
        if ((avs_writedata[2:1] == MODE_BOUNCE) && (r_mode != MODE_BOUNCE)) r_dir_right <= 1'b0;
      end

      // A CPU pattern write while running re-enters UPDATE so the next step is a full period later
      case (r_state)
        ST_IDLE: begin
          if (w_en_nxt) begin
            r_state <= ST_COUNT;
            r_cnt   <= w_reload;
          end
        end
        ST_COUNT: begin
          if (!w_en_nxt)                     r_state <= ST_IDLE;
          else if (w_wr_pattern)             r_state <= ST_UPDATE;
          else if (r_cnt == '0)              r_state <= ST_UPDATE;
          else                               r_cnt   <= r_cnt - CNT_WIDTH'(1);
        end
        ST_UPDATE: begin
          if (!w_en_nxt)                     r_state <= ST_IDLE;
          else if (!w_wr_pattern) begin
            r_state <= ST_COUNT;
            r_cnt   <= w_reload;
          end
        end
        default:                             r_state <= ST_IDLE;
      endcase
    end
  end

  assign pio_chipselect = r_pio_cs;
  assign pio_write_n    = r_pio_wn;
  assign pio_address    = 2'd0;
  assign pio_writedata  = r_pio_wd;
  assign irq            = r_irq;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed scenarios followed by random register traffic; every cycle the
//   PIO master outputs and irq are compared with a reference model that tracks
//   the absolute cycle number of the next scheduled step.
module tb_led_pattern_sequencer;

  localparam logic [31:0] MASK = 32'h0003_FFFF;
  localparam logic [31:0] DEF_PERIOD = 32'd50000000;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;
  logic        irq;

  led_pattern_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_address    (pio_address),
    .pio_writedata  (pio_writedata),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers plus the absolute edge index of the next step
  bit          m_en, m_irq_en, m_run, m_step, m_dir, exp_strobe;
  logic [1:0]  m_mode;
  logic [31:0] m_period, m_pat, m_wd;
  int          m_edge, m_next;

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_run = 0; m_step = 0; m_dir = 0; exp_strobe = 0;
    m_mode = 2'd0; m_period = DEF_PERIOD; m_pat = 32'd0; m_wd = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_irq_en, m_mode, m_en};
      2'd1:    return m_period;
      2'd2:    return m_pat;
      default: return {30'd0, m_step, m_run};
    endcase
  endfunction

  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [31:0] d);
    bit ctrl_w, pat_w, step, en_new;
    int eff;
    logic [31:0] np;
    m_edge++;
    ctrl_w = wr && (a == 2'd0);
    pat_w  = wr && (a == 2'd2);
    en_new = ctrl_w ? d[0] : m_en;
    step   = m_run && (m_edge == m_next) && en_new && !pat_w;
    exp_strobe = 0;
    if (wr && a == 2'd1) m_period = d;
    eff = (m_period < 2) ? 2 : int'(m_period);
    if (step) begin
      case (m_mode)
        2'd0: np = ((m_pat << 1) | (m_pat >> 17)) & MASK;
        2'd1: np = ((m_pat >> 1) | (m_pat << 17)) & MASK;
        2'd2: begin
          np = m_dir ? (m_pat >> 1) : ((m_pat << 1) & MASK);
          if (np[17])     m_dir = 1;
          else if (np[0]) m_dir = 0;
        end
        default: np = (m_pat + 1) & MASK;
      endcase
      m_pat = np; m_wd = np; m_step = 1; exp_strobe = 1;
      m_next = m_edge + eff;
    end
    if (pat_w) begin
      m_pat = d & MASK; m_wd = m_pat; exp_strobe = 1;
      if (m_run) m_next = m_edge + eff;
    end
    if (wr && a == 2'd3 && d[1] && !step) m_step = 0;
    if (ctrl_w) begin
      if (d[2:1] == 2'd2 && m_mode != 2'd2) m_dir = 0;
      m_mode = d[2:1]; m_irq_en = d[3]; m_en = d[0];
      if (!m_run && d[0]) begin
        m_run = 1;
        m_next = m_edge - 1 + eff;
      end else if (m_run && !d[0]) begin
        m_run = 0;
      end
    end
  endtask

  // One bus cycle: drive, optionally check readback, clock, compare all outputs
  task automatic cyc(input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_chipselect = wr | rd; avs_write_n = !wr; avs_writedata = d;
    #1;
    if (rd) check_eq($sformatf("readback[%0d]", a), avs_readdata, model_read(a));
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    avs_chipselect = 0; avs_write_n = 1;
    check_eq("pio_chipselect", {31'd0, pio_chipselect}, {31'd0, exp_strobe});
    check_eq("pio_write_n", {31'd0, pio_write_n}, {31'd0, !exp_strobe});
    check_eq("pio_writedata", pio_writedata, m_wd);
    check_eq("irq", {31'd0, irq}, {31'd0, m_step & m_irq_en});
    check_eq("pio_address", {30'd0, pio_address}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(1, 0, a, d); endtask
  task automatic rd(input logic [1:0] a);                       cyc(0, 1, a, 32'd0); endtask
  task automatic idle();                                         cyc(0, 0, 2'd0, 32'd0); endtask

  task automatic wait_write(output int n, output logic [31:0] data);
    n = 0;
    do begin
      idle();
      n++;
    end while (!pio_chipselect && n < 200);
    if (!pio_chipselect) check_eq("wait_write_timeout", {31'd0, pio_chipselect}, 32'd1);
    data = pio_writedata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt, r;
    logic [31:0] d;
    logic [1:0]  a;
    reset_n = 0; avs_address = 0; avs_chipselect = 0; avs_write_n = 1; avs_writedata = 0;
    model_reset();
    m_edge = 0; m_next = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // Reset values
    check_eq("rst_pio_cs", {31'd0, pio_chipselect}, 32'd0);
    check_eq("rst_pio_wn", {31'd0, pio_write_n}, 32'd1);
    check_eq("rst_pio_wd", pio_writedata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) rd(2'(i));

    // Rotate left, period 4
    wr(1, 32'd4); wr(2, 32'h1); wr(0, 32'h1);
    wait_write(n, d); check_eq("rotl_lat1", n, 3); check_eq("rotl_d1", d, 32'h2);
    wait_write(n, d); check_eq("rotl_lat2", n, 4); check_eq("rotl_d2", d, 32'h4);
    wait_write(n, d); check_eq("rotl_lat3", n, 4); check_eq("rotl_d3", d, 32'h8);

    // Bounce, period 3
    wr(0, 32'h0); wr(1, 32'd3); wr(2, 32'h10000); wr(0, 32'h5);
    wait_write(n, d); check_eq("bnc_lat1", n, 2); check_eq("bnc_d1", d, 32'h20000);
    wait_write(n, d); check_eq("bnc_lat2", n, 3); check_eq("bnc_d2", d, 32'h10000);
    wait_write(n, d); check_eq("bnc_d3", d, 32'h08000);
    wr(0, 32'h0); wr(2, 32'h1); wr(0, 32'h5);
    wait_write(n, d); check_eq("bnc_low", d, 32'h2);

    // Count mode wrap with irq
    wr(0, 32'h0); wr(2, 32'h3FFFE); wr(0, 32'hF);
    wait_write(n, d); check_eq("cnt_d1", d, 32'h3FFFF);
    check_eq("cnt_irq_set", {31'd0, irq}, 32'd1);
    wait_write(n, d); check_eq("cnt_wrap", d, 32'h0);
    wr(3, 32'h2);
    check_eq("cnt_irq_w1c", {31'd0, irq}, 32'd0);
    rd(3);

    // Short periods and CPU write on a step cycle
    wr(0, 32'h0); wr(1, 32'd0); wr(2, 32'h1); wr(0, 32'h1);
    wait_write(n, d); check_eq("p0_lat1", n, 1);
    wait_write(n, d); check_eq("p0_lat2", n, 2);
    idle(); wr(2, 32'h155);
    check_eq("cpu_wins", pio_writedata, 32'h155);
    wait_write(n, d); check_eq("cpu_next_lat", n, 2); check_eq("cpu_next_d", d, 32'h2AA);
    wr(1, 32'd1);
    wait_write(n, d);
    wait_write(n, d); check_eq("p1_lat", n, 2);

    // Disable while counting
    wr(1, 32'd10); wait_write(n, d);
    wr(0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (pio_chipselect) cnt++;
    end
    check_eq("no_write_after_disable", cnt, 0);

    // Reset asserted during UPDATE
    wr(1, 32'd3); wr(0, 32'h1);
    wait_write(n, d);
    #1 reset_n = 0;
    #1;
    check_eq("rst_mid_cs", {31'd0, pio_chipselect}, 32'd0);
    check_eq("rst_mid_wn", {31'd0, pio_write_n}, 32'd1);
    check_eq("rst_mid_wd", pio_writedata, 32'd0);
    @(negedge clk); @(negedge clk) reset_n = 1;
    model_reset();
    @(posedge clk); m_edge++; #1;
    rd(1); rd(3);

    // Random register traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = 2'($urandom_range(0, 3));
      if (r <= 5)      idle();
      else if (r == 6) rd(a);
      else begin
        d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
        wr(a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
